// File: rtl/mem_bus_master.sv
// -----------------------------------------------------------------------------
// mem_bus_master
// MEM-stage load/store initiator. Turns a single-cycle load/store request from
// the pipeline into a req/ack transaction on the data bus, handling byte/half/
// word sizing, byte-lane steering, alignment checking and load extension, and
// stalls the pipeline until the responder acknowledges.
//
// Optional feature macro: MEM_BUS_TIMEOUT_EN
//   defined   : REQ aborts after TIMEOUT_CYCLES cycles without bus_ack,
//               completing with mem_rdata=0 and bus_err=1.
//   undefined : REQ waits indefinitely, bus_err is tied 0.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   mem_rd, mem_wr    load / store request (store has priority)
//   mem_size          00 byte, 01 half, 10 word, 11 illegal
//   mem_signed        sign-extend byte/half loads
//   mem_addr          byte address
//   mem_wdata         right-justified store data
//   mem_rdata         extended load result, valid while done=1
//   stall             pipeline freeze
//   done              one-cycle completion pulse
//   align_err         one-cycle misaligned/illegal-size pulse
//   bus_err           one-cycle timeout pulse, coincides with done
//   bus_req           bus request, held until ack
//   bus_we            1 write, 0 read
//   bus_addr          word-aligned bus address
//   bus_be            byte enables, little-endian lanes
//   bus_wdata         lane-replicated store data
//   bus_ack           responder acknowledge (single cycle)
//   bus_rdata         read word, valid with bus_ack
// -----------------------------------------------------------------------------
module mem_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        stall,
  output logic        done,
  output logic        align_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      r_state;
  state_t      w_next;

  logic        w_req;
  logic        w_legal;
  logic        w_start;
  logic        w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;

  logic [31:0] r_mem_rdata;
  logic        r_bus_err;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_signed;

  assign w_req   = mem_rd | mem_wr;
  assign w_start = (r_state == S_IDLE) && w_req && w_legal;

  // Alignment / size legality of the presented request
  always_comb begin
    w_legal = 1'b0;
    case (mem_size)
      SZ_BYTE: w_legal = 1'b1;
      SZ_HALF: w_legal = ~mem_addr[0];
      SZ_WORD: w_legal = (mem_addr[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  // Byte-lane enables and replicated store data
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_wdata;
    case (mem_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << mem_addr[1:0];
        w_wdata = {4{mem_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be    = 4'b0011 << {mem_addr[1], 1'b0};
        w_wdata = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction and sign/zero extension of the returned word
  always_comb begin
    w_byte = bus_rdata[7:0];
    case (r_lane)
      2'd0: w_byte = bus_rdata[7:0];
      2'd1: w_byte = bus_rdata[15:8];
      2'd2: w_byte = bus_rdata[23:16];
      2'd3: w_byte = bus_rdata[31:24];
      default: ;
    endcase
    w_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_size)
      SZ_BYTE: w_ld = {{24{r_signed & w_byte[7]}}, w_byte};
      SZ_HALF: w_ld = {{16{r_signed & w_half[15]}}, w_half};
      default: w_ld = bus_rdata;
    endcase
  end

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;

  logic [CNT_W-1:0] r_tmo_cnt;

  // Counts REQ cycles that pass without an acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_start) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_REQ) && !bus_ack) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end

  // Last allowed REQ cycle without ack; an ack on that cycle still wins
  assign w_tmo = (r_state == S_REQ) && !bus_ack &&
                 (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = TIMEOUT_CYCLES;
  assign w_tmo        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_REQ;
      S_REQ:  if (bus_ack || w_tmo) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded handshake outputs; align_err/stall look at the live request
  always_comb begin
    bus_req   = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    align_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall     = w_start;
        align_err = w_req && !w_legal;
      end
      S_REQ: begin
        bus_req = 1'b1;
        stall   = 1'b1;
      end
      S_RESP: done = 1'b1;
      default: ;
    endcase
  end

  // Bus-side request registers and load result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_rdata <= '0;
      r_bus_err   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_lane      <= '0;
      r_size      <= '0;
      r_signed    <= 1'b0;
    end else begin
      if (w_start) begin
        r_bus_addr  <= {mem_addr[31:2], 2'b00};
        r_bus_we    <= mem_wr;
        r_bus_be    <= w_be;
        r_bus_wdata <= w_wdata;
        r_lane      <= mem_addr[1:0];
        r_size      <= mem_size;
        r_signed    <= mem_signed;
      end
      if (r_state == S_REQ) begin
        if (bus_ack) begin
          if (!r_bus_we) r_mem_rdata <= w_ld;
        end else if (w_tmo) begin
          r_mem_rdata <= '0;
        end
      end
      // w_tmo only fires on the REQ->RESP edge, so this lines up with done
      r_bus_err <= w_tmo;
    end
  end

  assign mem_rdata = r_mem_rdata;
  assign bus_err   = r_bus_err;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_bus_master.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_master
// Self-checking bench for mem_bus_master. Expected bus requests and load
// results are queued when an access is driven; a negedge monitor compares them
// when bus_req rises and when done pulses. With MEM_BUS_TIMEOUT_EN defined the
// timeout path is exercised as well (TIMEOUT_CYCLES=4).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_bus_master;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        done;
  logic        align_err;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_req;

  mem_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_size   (mem_size),
    .mem_signed (mem_signed),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .done       (done),
    .align_err  (align_err),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn,
                                           input logic [1:0] a, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * int'(a)));
    h = 16'(w >> (16 * int'(a[1])));
    case (size)
      2'b00:   return sgn ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   return sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Scoreboard monitor: bus fields on bus_req rise, result on done
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          check("spurious_req", 32'd1, 32'd0);
        end else begin
          check("bus_we",   32'(bus_we), 32'(exp_q[0].we));
          check("bus_addr", bus_addr,    exp_q[0].addr);
          check("bus_be",   32'(bus_be), 32'(exp_q[0].be));
          if (exp_q[0].we) check("bus_wdata", bus_wdata, exp_q[0].wdata);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("mem_rdata", mem_rdata,    mon_e.rdata);
          check("bus_err",   32'(bus_err), 32'(mon_e.err));
        end
      end
    end
    prev_req = bus_req;
  end

  // One access acknowledged on cycle ack_cyc (request presented on cycle 0)
  task automatic access(input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_cyc, input logic [31:0] rdata_in,
                        input logic [31:0] exp_rd, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd);
    exp_t e;
    int   stall_cnt;
    e.rdata = exp_rd;
    e.err   = 1'b0;
    e.we    = wr;
    e.addr  = {addr[31:2], 2'b00};
    e.be    = exp_be;
    e.wdata = exp_wd;
    exp_q.push_back(e);
    stall_cnt = 0;
    @(posedge clk); #1;
    mem_rd     = ~wr;
    mem_wr     = wr;
    mem_size   = size;
    mem_signed = sgn;
    mem_addr   = addr;
    mem_wdata  = wdata;
    for (int c = 0; c <= ack_cyc; c++) begin
      if (c == ack_cyc) begin
        bus_ack   = 1'b1;
        bus_rdata = rdata_in;
      end
      @(negedge clk);
      if (stall) stall_cnt++;
      if (c == 0) check("req_cycle0", 32'(bus_req), 32'd0);
      else        check("req_held",   32'(bus_req), 32'd1);
      @(posedge clk); #1;
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
    end
    @(negedge clk);
    if (stall) stall_cnt++;
    check("done_pulse",   32'(done),    32'd1);
    check("req_dropped",  32'(bus_req), 32'd0);
    check("stall_cycles", 32'(stall_cnt), 32'(ack_cyc + 1));
    @(posedge clk); #1;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
  endtask

  // Misaligned or illegal request presented for one cycle
  task automatic misaligned(input logic wr, input logic [1:0] size, input logic [31:0] addr);
    @(posedge clk); #1;
    mem_rd   = ~wr;
    mem_wr   = wr;
    mem_size = size;
    mem_addr = addr;
    @(negedge clk);
    check("align_err_hi", 32'(align_err), 32'd1);
    check("align_stall",  32'(stall),     32'd0);
    check("align_noreq",  32'(bus_req),   32'd0);
    @(posedge clk); #1;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    @(negedge clk);
    check("align_err_lo", 32'(align_err), 32'd0);
    check("align_idle",   32'(bus_req),   32'd0);
  endtask

  initial begin
    int   sz;
    logic sg;
    logic [31:0] a;
    logic [31:0] rd;
    n_tests    = 0;
    n_fail     = 0;
    prev_req   = 1'b0;
    rst_n      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_size   = 2'b00;
    mem_signed = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    bus_ack    = 1'b0;
    bus_rdata  = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_rdata", mem_rdata,        32'd0);
    check("rst_outs", {26'd0, stall, done, align_err, bus_err, bus_req, bus_we}, 32'd0);
    check("rst_bus_addr",  bus_addr,         32'd0);
    check("rst_bus_be",    32'(bus_be),      32'd0);
    check("rst_bus_wdata", bus_wdata,        32'd0);
    rst_n = 1'b1;

    // Directed accesses
    access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        3, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 32'h0);
    access(1'b0, 2'b00, 1'b1, 32'h203, 32'h0,        1, 32'h80FF0000, 32'hFFFFFF80, 4'b1000, 32'h0);
    access(1'b0, 2'b00, 1'b0, 32'h203, 32'h0,        2, 32'h80FF0000, 32'h00000080, 4'b1000, 32'h0);
    access(1'b1, 2'b01, 1'b0, 32'h302, 32'h1234ABCD, 2, 32'h0,        32'h00000080, 4'b1100, 32'hABCDABCD);
    access(1'b1, 2'b00, 1'b0, 32'h101, 32'h00000055, 1, 32'hFFFFFFFF, 32'h00000080, 4'b0010, 32'h55555555);
    access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0,        1, 32'hBEEF1234, 32'h0000BEEF, 4'b1100, 32'h0);
    access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0,        4, 32'hBEEF1234, 32'hFFFFBEEF, 4'b1100, 32'h0);
    access(1'b0, 2'b00, 1'b1, 32'h101, 32'h0,        1, 32'h00007F00, 32'h0000007F, 4'b0010, 32'h0);
    access(1'b1, 2'b10, 1'b0, 32'h10C, 32'hCAFEF00D, 1, 32'h0,        32'h0000007F, 4'b1111, 32'hCAFEF00D);

    // Alignment / illegal size
    misaligned(1'b0, 2'b10, 32'h101);
    misaligned(1'b0, 2'b01, 32'h103);
    misaligned(1'b1, 2'b10, 32'h102);
    misaligned(1'b0, 2'b11, 32'h200);

    // Stray ack while idle
    @(posedge clk); #1 bus_ack = 1'b1;
    @(posedge clk); #1 bus_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_done", 32'(done),    32'd0);
    check("stray_ack_req",  32'(bus_req), 32'd0);

    // Random legal loads against the reference extension model
    for (int i = 0; i < 8; i++) begin
      sz = $urandom_range(0, 2);
      sg = 1'($urandom_range(0, 1));
      a  = $urandom & 32'h0000FFFF;
      if (sz == 1) a[0]   = 1'b0;
      if (sz == 2) a[1:0] = 2'b00;
      rd = $urandom;
      access(1'b0, 2'(sz), sg, a, 32'h0, $urandom_range(1, 4), rd,
             ref_load(2'(sz), sg, a[1:0], rd), ref_be(2'(sz), a[1:0]), 32'h0);
    end

    // Reset in the middle of a transaction
    @(posedge clk); #1;
    mem_rd     = 1'b1;
    mem_size   = 2'b01;
    mem_signed = 1'b1;
    mem_addr   = 32'h10;
    @(posedge clk); #1;
    check("rst_mid_req_pre", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req_drop", 32'(bus_req), 32'd0);
    check("rst_mid_no_done",  32'(done),    32'd0);
    @(posedge clk); #1 mem_rd = 1'b0;
    @(negedge clk);
    check("rst_mid_idle_done", 32'(done),    32'd0);
    check("rst_mid_idle_req",  32'(bus_req), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_done_after", 32'(done),  32'd0);
    check("rst_mid_rdata",      mem_rdata,  32'd0);
    access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 2, 32'h12348765, 32'hFFFF8765, 4'b0011, 32'h0);

`ifdef MEM_BUS_TIMEOUT_EN
    begin
      exp_t e;
      int   req_cnt;
      logic got;
      e.rdata = 32'h0;
      e.err   = 1'b1;
      e.we    = 1'b0;
      e.addr  = 32'h400;
      e.be    = 4'b1111;
      e.wdata = 32'h0;
      exp_q.push_back(e);
      req_cnt = 0;
      got     = 1'b0;
      @(posedge clk); #1;
      mem_rd   = 1'b1;
      mem_size = 2'b10;
      mem_addr = 32'h400;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (bus_req) req_cnt++;
        if (done) begin
          got = 1'b1;
          break;
        end
      end
      check("tmo_done_seen",  32'(got),     32'd1);
      check("tmo_req_cycles", 32'(req_cnt), 32'd4);
      @(posedge clk); #1 mem_rd = 1'b0;
      @(negedge clk);
      check("tmo_err_pulse", 32'(bus_err), 32'd0);
    end
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
